uart_fifo: RTL

Memory-mapped UART peripheral for the picoRV SoC bus with parametrised RX/TX FIFOs, runtime-selectable stop bits, sticky error flags and level interrupts. It sits on the CPU's `select`/`wstrb`/`addr`/`data_i` bus as an 8-register slave and drives the external `rx`/`tx` pins. It replaces the single-byte UART peripheral wherever buffering or error reporting is needed.

---
 rtl/uart_fifo.sv | 389 ++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo.sv
// uart_fifo: memory-mapped UART with RX/TX byte FIFOs, sticky error flags
// and level interrupts.
//
// Optional feature: define UART_PARITY_EN to build the parity stage into both
// engines (CONFIG.PAR, STATUS.PERR). Without it, frames are 8N1/8N2 only and
// the parity bits of CONFIG and STATUS read as zero.
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   select, wstrb, addr,    bus request (wstrb = 0 read, else full-word write),
//   data_i                  byte offset, write data
//   ready, data_o           one-cycle acknowledge and read data
//   rx, tx                  serial input (asynchronous) / output (idle high)
//   irq_rx, irq_tx          level interrupts
//
// Registers: 0x00 CONFIG, 0x04 BAUD, 0x08 STATUS, 0x0C RXDATA, 0x10 TXDATA.
module uart_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_RESET = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        select,
    input  logic [3:0]  wstrb,
    input  logic [4:0]  addr,
    input  logic [31:0] data_i,
    output logic        ready,
    output logic [31:0] data_o,
    input  logic        rx,
    output logic        tx,
    output logic        irq_rx,
    output logic        irq_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;

    // ---------------- bus decode ----------------
    logic accept, is_wr, wr_cfg, wr_baud, wr_stat, soft_clr;
    assign accept   = select & ~ready;
    assign is_wr    = |wstrb;
    assign wr_cfg   = accept & is_wr & (addr == 5'h00);
    assign wr_baud  = accept & is_wr & (addr == 5'h04);
    assign wr_stat  = accept & is_wr & (addr == 5'h08);
    assign soft_clr = wr_cfg & data_i[0];

    logic        en_reg, rxie_reg, txie_reg, stop2_reg;
    logic [15:0] baud_reg;
    logic [1:0]  par_rd;
    logic        ovr_reg, ferr_reg, txovf_reg, perr_rd;
    logic        engine_on;
    assign engine_on = en_reg & (baud_reg >= 16'd4);

    // ---------------- FIFOs: index 0 = RX, index 1 = TX ----------------
    logic [1:0]    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level [2];
    logic [7:0]    fifo_wdata [2];
    logic [7:0]    fifo_rdata [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : fifo_g
            logic [LW-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [7:0]    mem [FIFO_DEPTH];
            logic [7:0]    rdata_reg;

            assign fifo_level[gi] = wr_ptr_reg - rd_ptr_reg;
            assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
            assign fifo_full[gi]  = (fifo_level[gi] == LW'(FIFO_DEPTH));
            assign fifo_rdata[gi] = rdata_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else if (soft_clr) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end

            // Head is captured on pop; a same-cycle write to the same slot
            // (full FIFO) lands after the read, so the old head is returned.
            always_ff @(posedge clk) begin
                if (fifo_push[gi]) mem[wr_ptr_reg[AW-1:0]] <= fifo_wdata[gi];
                if (fifo_pop[gi])  rdata_reg <= mem[rd_ptr_reg[AW-1:0]];
            end
        end
    endgenerate

    logic rx_pop, rx_push, rx_push_req, tx_pop, tx_push, tx_push_req;
    logic [7:0] rx_shift_reg;
    assign rx_pop      = accept & ~is_wr & (addr == 5'h0C) & ~fifo_empty[0];
    assign rx_push     = rx_push_req & (~fifo_full[0] | rx_pop);
    assign tx_push_req = accept & is_wr & (addr == 5'h10);
    assign tx_push     = tx_push_req & (~fifo_full[1] | tx_pop);
    assign fifo_push   = {tx_push, rx_push};
    assign fifo_pop    = {tx_pop, rx_pop};
    assign fifo_wdata[0] = rx_shift_reg;
    assign fifo_wdata[1] = data_i[7:0];

    // ---------------- configuration and sticky flags ----------------
    logic rx_ferr_set;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_reg <= 1'b0; rxie_reg <= 1'b0; txie_reg <= 1'b0; stop2_reg <= 1'b0;
            baud_reg <= 16'(BAUD_RESET);
            ovr_reg <= 1'b0; ferr_reg <= 1'b0; txovf_reg <= 1'b0;
        end else begin
            if (wr_cfg) begin
                en_reg    <= data_i[1] & ~data_i[0];
                rxie_reg  <= data_i[2] & ~data_i[0];
                txie_reg  <= data_i[3] & ~data_i[0];
                stop2_reg <= data_i[4] & ~data_i[0];
            end
            if (wr_baud) baud_reg <= data_i[15:0];
            if (soft_clr) begin
                ovr_reg <= 1'b0; ferr_reg <= 1'b0; txovf_reg <= 1'b0;
            end else begin
                // hardware set beats a same-cycle write-1-to-clear
                ovr_reg   <= (rx_push_req & fifo_full[0] & ~rx_pop) | (ovr_reg & ~(wr_stat & data_i[5]));
                ferr_reg  <= rx_ferr_set | (ferr_reg & ~(wr_stat & data_i[6]));
                txovf_reg <= (tx_push_req & ~tx_push) | (txovf_reg & ~(wr_stat & data_i[8]));
            end
        end
    end

`ifdef UART_PARITY_EN
    logic [1:0] par_reg;
    logic       perr_reg, rx_perr_set;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_reg  <= 2'b00;
            perr_reg <= 1'b0;
        end else begin
            if (wr_cfg) par_reg <= data_i[0] ? 2'b00 : data_i[6:5];
            if (soft_clr) perr_reg <= 1'b0;
            else          perr_reg <= rx_perr_set | (perr_reg & ~(wr_stat & data_i[7]));
        end
    end
    assign par_rd  = par_reg;
    assign perr_rd = perr_reg;
`else
    assign par_rd  = 2'b00;
    assign perr_rd = 1'b0;
`endif

    // ---------------- TX engine ----------------
    uart_state_t tx_state_reg, tx_state_next;
    logic [15:0] tx_cnt_reg, tx_cnt_next, tx_len_reg, tx_len_next;
    logic [7:0]  tx_shift_reg, tx_shift_next;
    logic [2:0]  tx_bit_reg, tx_bit_next;
    logic        tx_stop2nd_reg, tx_stop2nd_next, tx_reg, tx_next, tx_last;
`ifdef UART_PARITY_EN
    logic        tx_par_reg, tx_par_next;
`endif
    assign tx_last = (tx_cnt_reg == tx_len_reg - 16'd1);

    always_comb begin
        tx_state_next   = tx_state_reg;
        tx_cnt_next     = tx_cnt_reg + 16'd1;
        tx_len_next     = tx_len_reg;
        tx_shift_next   = tx_shift_reg;
        tx_bit_next     = tx_bit_reg;
        tx_stop2nd_next = tx_stop2nd_reg;
        tx_next         = tx_reg;
        tx_pop          = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_next     = tx_par_reg;
`endif
        if (!engine_on) begin
            tx_state_next = S_IDLE;
            tx_cnt_next   = 16'd0;
            tx_next       = 1'b1;
        end else begin
            case (tx_state_reg)
                S_IDLE: begin
                    tx_cnt_next = 16'd0;
                    tx_next     = 1'b1;
                    if (!fifo_empty[1]) begin
                        tx_pop = 1'b1; tx_state_next = S_START;
                        tx_len_next = baud_reg; tx_next = 1'b0;
                    end
                end
                S_START: if (tx_last) begin
                    // popped byte is available from the FIFO read register by now
                    tx_state_next = S_DATA; tx_cnt_next = 16'd0; tx_len_next = baud_reg;
                    tx_shift_next = fifo_rdata[1]; tx_bit_next = 3'd0;
                    tx_next       = fifo_rdata[1][0];
`ifdef UART_PARITY_EN
                    tx_par_next   = (^fifo_rdata[1]) ^ par_reg[1];
`endif
                end
                S_DATA: if (tx_last) begin
                    tx_cnt_next = 16'd0; tx_len_next = baud_reg;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = S_STOP; tx_next = 1'b1; tx_stop2nd_next = 1'b0;
`ifdef UART_PARITY_EN
                        if (par_reg != 2'b00) begin
                            tx_state_next = S_PARITY; tx_next = tx_par_reg;
                        end
`endif
                    end else begin
                        tx_bit_next   = tx_bit_reg + 3'd1;
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        tx_next       = tx_shift_reg[1];
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: if (tx_last) begin
                    tx_state_next = S_STOP; tx_cnt_next = 16'd0; tx_len_next = baud_reg;
                    tx_next = 1'b1; tx_stop2nd_next = 1'b0;
                end
`endif
                S_STOP: if (tx_last) begin
                    tx_cnt_next = 16'd0; tx_len_next = baud_reg;
                    if (stop2_reg && !tx_stop2nd_reg) begin
                        tx_stop2nd_next = 1'b1;
                    end else if (!fifo_empty[1]) begin
                        // chain straight into the next frame with no idle gap
                        tx_pop = 1'b1; tx_state_next = S_START; tx_next = 1'b0;
                    end else begin
                        tx_state_next = S_IDLE;
                    end
                end
                default: tx_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || soft_clr) begin
            tx_state_reg <= S_IDLE; tx_cnt_reg <= '0; tx_len_reg <= '0;
            tx_shift_reg <= '0; tx_bit_reg <= '0; tx_stop2nd_reg <= 1'b0; tx_reg <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_reg <= 1'b0;
`endif
        end else begin
            tx_state_reg <= tx_state_next; tx_cnt_reg <= tx_cnt_next; tx_len_reg <= tx_len_next;
            tx_shift_reg <= tx_shift_next; tx_bit_reg <= tx_bit_next;
            tx_stop2nd_reg <= tx_stop2nd_next; tx_reg <= tx_next;
`ifdef UART_PARITY_EN
            tx_par_reg <= tx_par_next;
`endif
        end
    end

    // ---------------- RX engine ----------------
    logic        rx_meta_reg, rx_sync_reg, rx_prev_reg, rx_last;
    uart_state_t rx_state_reg, rx_state_next;
    logic [15:0] rx_cnt_reg, rx_cnt_next, rx_len_reg, rx_len_next;
    logic [7:0]  rx_shift_next;
    logic [2:0]  rx_bit_reg, rx_bit_next;
`ifdef UART_PARITY_EN
    logic        rx_perr_reg, rx_perr_next;
`endif
    assign rx_last = (rx_cnt_reg == rx_len_reg - 16'd1);

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg + 16'd1;
        rx_len_next   = rx_len_reg;
        rx_shift_next = rx_shift_reg;
        rx_bit_next   = rx_bit_reg;
        rx_push_req   = 1'b0;
        rx_ferr_set   = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_next  = rx_perr_reg;
        rx_perr_set   = 1'b0;
`endif
        if (!engine_on) begin
            rx_state_next = S_IDLE;
            rx_cnt_next   = 16'd0;
        end else begin
            case (rx_state_reg)
                S_IDLE: begin
                    rx_cnt_next = 16'd0;
                    if (rx_prev_reg && !rx_sync_reg) begin
                        rx_state_next = S_START; rx_len_next = baud_reg >> 1;
                    end
                end
                // mid-start check rejects glitches shorter than half a bit
                S_START: if (rx_last) begin
                    if (!rx_sync_reg) begin
                        rx_state_next = S_DATA; rx_cnt_next = 16'd0;
                        rx_len_next = baud_reg; rx_bit_next = 3'd0;
`ifdef UART_PARITY_EN
                        rx_perr_next = 1'b0;
`endif
                    end else begin
                        rx_state_next = S_IDLE;
                    end
                end
                S_DATA: if (rx_last) begin
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_cnt_next = 16'd0; rx_len_next = baud_reg;
                    if (rx_bit_reg == 3'd7) begin
                        rx_state_next = S_STOP;
`ifdef UART_PARITY_EN
                        if (par_reg != 2'b00) rx_state_next = S_PARITY;
`endif
                    end else begin
                        rx_bit_next = rx_bit_reg + 3'd1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: if (rx_last) begin
                    rx_perr_next  = rx_sync_reg ^ (^rx_shift_reg) ^ par_reg[1];
                    rx_state_next = S_STOP; rx_cnt_next = 16'd0; rx_len_next = baud_reg;
                end
`endif
                S_STOP: if (rx_last) begin
                    rx_state_next = S_IDLE;
                    if (!rx_sync_reg) rx_ferr_set = 1'b1;
`ifdef UART_PARITY_EN
                    else if (rx_perr_reg) rx_perr_set = 1'b1;
`endif
                    else rx_push_req = 1'b1;
                end
                default: rx_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1; rx_sync_reg <= 1'b1; rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx; rx_sync_reg <= rx_meta_reg; rx_prev_reg <= rx_sync_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || soft_clr) begin
            rx_state_reg <= S_IDLE; rx_cnt_reg <= '0; rx_len_reg <= '0;
            rx_shift_reg <= '0; rx_bit_reg <= '0;
`ifdef UART_PARITY_EN
            rx_perr_reg <= 1'b0;
`endif
        end else begin
            rx_state_reg <= rx_state_next; rx_cnt_reg <= rx_cnt_next; rx_len_reg <= rx_len_next;
            rx_shift_reg <= rx_shift_next; rx_bit_reg <= rx_bit_next;
`ifdef UART_PARITY_EN
            rx_perr_reg <= rx_perr_next;
`endif
        end
    end

    // ---------------- read path and outputs ----------------
    logic        tx_busy, rd_fifo_reg;
    logic [31:0] status_word, rd_word, rd_word_reg;
    assign tx_busy = (tx_state_reg != S_IDLE);
    assign status_word = {8'(fifo_level[1]), 8'(fifo_level[0]), 7'b0, txovf_reg, perr_rd,
                          ferr_reg, ovr_reg, tx_busy, fifo_empty[1], fifo_full[1],
                          fifo_full[0], ~fifo_empty[0]};

    always_comb begin
        rd_word = 32'd0;
        case (addr)
            5'h00:   rd_word = {25'd0, par_rd, stop2_reg, txie_reg, rxie_reg, en_reg, 1'b0};
            5'h04:   rd_word = {16'd0, baud_reg};
            5'h08:   rd_word = status_word;
            default: rd_word = 32'd0;
        endcase
    end

    // RXDATA comes from the FIFO read register, which is loaded by the pop itself
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b0; rd_word_reg <= '0; rd_fifo_reg <= 1'b0;
        end else begin
            ready       <= accept;
            rd_word_reg <= (accept && !is_wr) ? rd_word : 32'd0;
            rd_fifo_reg <= rx_pop;
        end
    end

    assign data_o = rd_fifo_reg ? {24'd0, fifo_rdata[0]} : rd_word_reg;
    assign tx     = tx_reg;
    assign irq_rx = rxie_reg & ~fifo_empty[0];
    assign irq_tx = txie_reg & fifo_empty[1] & ~tx_busy;

    logic unused_ok;
    assign unused_ok = ^data_i[31:16];
endmodule
